// File: rtl/mem_port_sched_pkg.sv
// Shared types and default sizing for the memory port scheduler.
package mem_sched_pkg;
    localparam int NREQ_DEF     = 4;
    localparam int AW_DEF       = 10;
    localparam int DW_DEF       = 64;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        RESP   = 2'd2,
        LOCKED = 2'd3
    } state_t;
endpackage

// File: rtl/mem_port_sched_rr_pick.sv
// Combinational round-robin picker: first requester after last_g_i, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_g_i,
    output logic            valid_o,
    output logic [IW-1:0]   winner_o
);
    logic [IW-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        valid_o  = |req_i;
        winner_o = '0;
        idx      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_g_i) + k) % NREQ);
            if (req_i[idx]) winner_o = idx;
        end
    end
endmodule

// File: rtl/mem_port_sched.sv
// Arbitrates NREQ cores onto one synchronous RAM port, with bounded grant locking.
module mem_port_sched
    import mem_sched_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   g_q, g_d, last_g_q, pick_g;
    logic [7:0]      hold_q, hold_d;
    logic            pick_vld;
    logic [NREQ-1:0] ack_d;
    logic            we_sel;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [DW-1:0]   rdata_q;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i    (req),
        .last_g_i (last_g_q),
        .valid_o  (pick_vld),
        .winner_o (pick_g)
    );

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: if (pick_vld) begin
                g_d     = pick_g;
                state_d = XFER;
            end
            XFER: state_d = RESP;
            RESP: if (lock[g_q] && hold_q < HOLD_LIM) begin
                hold_d  = hold_q + 8'd1;
                state_d = LOCKED;
            end else begin
                hold_d  = '0;
                state_d = IDLE;
            end
            LOCKED: if (req[g_q]) begin
                state_d = XFER;
            end else if (!lock[g_q]) begin
                hold_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Port fields are captured on entry to XFER so they are registered outputs.
    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        ack_d     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_d == IW'(i)) begin
                we_sel    = we[i];
                addr_sel  = addr[i*AW +: AW];
                wdata_sel = wdata[i*DW +: DW];
            end
        end
        if (state_d == RESP) ack_d[g_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            last_g_q  <= IW'(NREQ - 1);
            hold_q    <= '0;
            ack       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            hold_q  <= hold_d;
            ack     <= ack_d;
            mem_en  <= (state_d == XFER);
            mem_we  <= (state_d == XFER) && we_sel;
            if (state_d == XFER) begin
                mem_addr  <= addr_sel;
                mem_wdata <= wdata_sel;
            end
            if (state_q == RESP) begin
                last_g_q <= g_q;
                rdata_q  <= mem_rdata;
            end
        end
    end

    // RAM data arrives in RESP itself, so it bypasses the holding register then.
    assign rdata = (state_q == RESP) ? mem_rdata : rdata_q;
endmodule

// File: doc/mem_port_sched.md
MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesting cores (2..8).
REQ-002 Parameter AW, default 10, memory address width.
REQ-003 Parameter DW, default 64, memory data width.
REQ-004 Parameter MAX_HOLD, default 8, max consecutive locked transactions per grant (1..255).
REQ-005 The reset SHALL be rst, asynchronous, active-high; the clock SHALL be clk.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req  input  NREQ  per-core transaction request, held until ack.
REQ-009 lock  input  NREQ  per-core request to retain the grant after the current transaction.
REQ-010 we  input  NREQ  per-core write enable (1 write, 0 read).
REQ-011 addr  input  NREQ*AW  per-core address, core i at bits [i*AW +: AW].
REQ-012 wdata  input  NREQ*DW  per-core write data, core i at bits [i*DW +: DW].
REQ-013 ack  output  NREQ  one-cycle completion pulse to the granted core.
REQ-014 rdata  output  DW  read data, valid while ack is high for a read.
REQ-015 mem_en, mem_we  output  1 each  memory port strobe and write select.
REQ-016 mem_addr, mem_wdata  output  AW, DW  memory port address and write data.
REQ-017 mem_rdata  input  DW  memory read data, one cycle after mem_en (synchronous RAM).

Function
REQ-018 The FSM SHALL have states IDLE, XFER, RESP and LOCKED.
REQ-019 In IDLE with any req high, the block SHALL register winner g by round-robin search starting at last_g+1 (mod NREQ) and enter XFER; with no req it SHALL remain in IDLE.
REQ-020 In XFER, the block SHALL assert mem_en for exactly one cycle with mem_we=we[g], mem_addr=addr[g], mem_wdata=wdata[g], then enter RESP.
REQ-021 In RESP, the block SHALL pulse ack[g] for one cycle, drive rdata=mem_rdata, and set last_g=g; req-to-ack latency is 2 cycles after the IDLE sample cycle.
REQ-022 From RESP, if lock[g]=1 and hold_cnt<MAX_HOLD-1, the block SHALL increment hold_cnt and enter LOCKED; otherwise it SHALL clear hold_cnt and enter IDLE.
REQ-023 In LOCKED, req[g]=1 SHALL enter XFER for g with no arbitration; req[g]=0 with lock[g]=0 SHALL return to IDLE; other cores SHALL be held off.
REQ-024 When hold_cnt reaches MAX_HOLD-1, the next RESP SHALL force IDLE so a competing core wins by rotation.
REQ-025 A req[g] drop during XFER SHALL not abort the access; ack[g] still pulses.
REQ-026 Outside XFER, mem_en and mem_we SHALL be 0; outside RESP, ack SHALL be all-zero and rdata SHALL hold its last value.
REQ-027 At most one ack bit and at most one mem_en cycle per transaction SHALL ever be asserted.

Reset
REQ-028 rst SHALL force IDLE, ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, hold_cnt=0 and last_g=NREQ-1, so core 0 wins the first contest.
REQ-029 Reset mid-transaction SHALL drop the in-flight access without issuing ack.

Structure
REQ-030 Package mem_sched_pkg SHALL hold the state enum and the default values of NREQ, AW, DW and MAX_HOLD.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_g; outputs valid, winner index).
REQ-032 The top SHALL contain the FSM, the winner, last_g and hold_cnt registers, and the output registers only.

Verification
REQ-033 Reset, then req=4'b1111 with lock=0 held -> acks to cores 0,1,2,3,0 in order, one every 3 cycles.
REQ-034 Core 2 writes addr 0x05 data 0xA5, then reads addr 0x05 -> mem_en pulses once per transaction, read ack carries rdata=0xA5.
REQ-035 Core 1 locked, req held, core 3 requesting, MAX_HOLD=8 -> 8 consecutive acks to core 1, then core 3 granted.
REQ-036 Core 0 drops req during XFER -> ack[0] still pulses in RESP, FSM returns to IDLE.
REQ-037 rst asserted during XFER -> no ack, outputs zero in the same cycle, then core 0 wins the next contest.
